inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage, directly upstream of the instruction decode field splitter.
- Holds the PC and issues word fetches to instruction memory over a request/grant plus response-valid interface, with at most one request outstanding.
- Presents a registered {valid, pc, instruction} word to decode.
- Takes stall from the hazard unit and redirect (branch/jump/flush) from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept; hold the output register
- redirect_valid  in  1  discard in-flight and presented work; load redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch word address, always 4-byte aligned
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction word
- if_valid  out  1  if_instruction/if_pc hold a live instruction
- if_pc  out  32  PC of the presented instruction
- if_pc_plus4  out  32  if_pc + 4, combinational from the if_pc register, mod 2^32
- if_instruction  out  32  instruction word to decode

Behaviour:
- Registers:
  - pc: next fetch address.
  - req_pc: address of the outstanding request.
  - state in {FETCH, WAIT, DROP}.
  - Output register: if_valid, if_pc, if_instruction.
- Reset, asynchronous on rst_n low:
  - pc=RESET_PC, req_pc=0, state=FETCH.
  - if_valid=0, if_pc=0, if_instruction=32'h0000_0000 (NOP).
  - imem_req=0 while rst_n low.
  - Reset mid-transaction abandons the request; a late imem_rvalid after reset release while in FETCH is ignored.
- imem_req = (state==FETCH) && !redirect_valid && (!if_valid || !stall). This is combinational.
- imem_addr = pc; bits [1:0] are always 0.
- FETCH:
  - imem_req && imem_gnt: req_pc<=pc, pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), state<=WAIT.
  - No grant: hold pc, keep requesting; the address must stay stable while req is high and unaccepted.
  - imem_rvalid in FETCH is ignored.
- WAIT:
  - imem_rvalid && !redirect_valid: if_valid<=1, if_pc<=req_pc, if_instruction<=imem_rdata, state<=FETCH.
  - This never overwrites a live word. A request is issued only when the output register is empty or is being consumed on that edge, so no skid buffer is needed.
- DROP (request outstanding but stale):
  - imem_rvalid: discard, state<=FETCH.
  - The output register is unaffected.
- Output consumption: the presented word is consumed at any edge with if_valid && !stall.
  - If no new response loads on that edge, if_valid<=0.
  - With stall=1, all output fields hold.
- Redirect (highest priority, any state):
  - pc<=redirect_pc & ~3, if_valid<=0; stall is ignored that cycle.
  - WAIT without rvalid: ->DROP.
  - WAIT with rvalid the same cycle: response discarded, ->FETCH.
  - DROP: stay DROP, pc updated.
  - FETCH: stay FETCH; no request is issued that cycle.
  - Back-to-back redirects: the last one wins.
- Latency:
  - From grant, a response with rvalid in cycle N gives if_valid=1 in N+1.
  - Maximum throughput is one instruction per 2 cycles, with zero-wait memory granting and responding in the cycle after grant.
- if_instruction and if_pc hold their last value when if_valid=0.

Test Plan:
- Reset then free-run: rst_n low, release, memory gnt=1 and rvalid one cycle after grant, stall=0 -> addresses 0x0,0x4,0x8 requested in order; if_pc 0x0,0x4,0x8 with matching rdata; if_pc_plus4=if_pc+4; if_valid drops between words.
- Stall hold: present word at pc 0x4 (rdata 0x8C220004), assert stall 5 cycles -> if_* unchanged, imem_req=0; release -> next request 0x8.
- Redirect in WAIT: grant at 0x10, then redirect_pc=0x200 before rvalid -> state DROP, response discarded, if_valid=0, next request 0x200, if_pc=0x200 later.
- Redirect with simultaneous rvalid and stall: if_valid=1 stalled, redirect_valid=1 in the same cycle rvalid arrives -> if_valid=0, response discarded, next imem_addr=0x300; misaligned redirect_pc 0x303 -> 0x300.
- Wrap and async reset: pc=0xFFFF_FFFC granted -> next imem_addr=0x0; assert rst_n low mid-WAIT -> outputs immediately at reset values; a late rvalid after release is ignored; the first request goes to RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, runs a single-outstanding imem request/grant/response
// handshake, and presents a registered {valid, pc, instruction} word to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        req;

  // Only request when the output slot is free or drains on this edge, so a response never
  // lands on a live word.
  assign req = rst_n && (state_reg == FETCH) && !redirect_valid && (!valid_reg || !stall);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    valid_next  = valid_reg;
    out_pc_next = out_pc_reg;
    instr_next  = instr_reg;

    if (redirect_valid) begin
      pc_next    = redirect_pc & ~32'h3;
      valid_next = 1'b0;
      // An outstanding request becomes stale unless its response retires it right now.
      if (state_reg != FETCH) begin
        state_next = imem_rvalid ? FETCH : DROP;
      end
    end else begin
      if (valid_reg && !stall) begin
        valid_next = 1'b0;
      end
      case (state_reg)
        FETCH: begin
          if (req && imem_gnt) begin
            req_pc_next = pc_reg;
            pc_next     = pc_reg + 32'd4;
            state_next  = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            valid_next  = 1'b1;
            out_pc_next = req_pc_reg;
            instr_next  = imem_rdata;
            state_next  = FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= 32'h0;
      valid_reg  <= 1'b0;
      out_pc_reg <= 32'h0;
      instr_reg  <= 32'h0000_0000;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      valid_reg  <= valid_next;
      out_pc_reg <= out_pc_next;
      instr_reg  <= instr_next;
    end
  end

  assign imem_req       = req;
  assign imem_addr      = {pc_reg[31:2], 2'b00};
  assign if_valid       = valid_reg;
  assign if_pc          = out_pc_reg;
  assign if_pc_plus4    = out_pc_reg + 32'd4;
  assign if_instruction = instr_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, hand-written wrap/async-reset sequence,
// then randomized traffic checked against a transaction-level reference model.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, redirect_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_pc_plus4, if_instruction;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_instruction(if_instruction)
  );

  typedef struct {
    logic        st, rv;
    logic [31:0] rpc;
    logic        g, r;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic st, logic rv, logic [31:0] rpc, logic g, logic r,
                              logic [31:0] rd, logic e_req, logic [31:0] e_addr, logic e_v,
                              logic [31:0] e_pc, logic [31:0] e_ins);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.g = g; v.r = r; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  function automatic logic [129:0] ev(logic req, logic [31:0] addr, logic v,
                                      logic [31:0] pc, logic [31:0] ins);
    return {req, addr, v, pc, ins, pc + 32'd4};
  endfunction

  task automatic chk(input string nm, input logic [129:0] exp, input bit verbose);
    logic [129:0] act;
    act = {imem_req, imem_addr, if_valid, if_pc, if_instruction, if_pc_plus4};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h v=%b pc=%h ins=%h p4=%h; want req=%b addr=%h v=%b pc=%h ins=%h p4=%h",
               nm, act[129], act[128:97], act[96], act[95:64], act[63:32], act[31:0],
               exp[129], exp[128:97], exp[96], exp[95:64], exp[63:32], exp[31:0]);
    end else if (verbose) begin
      $display("ok   %s: req=%b addr=%h v=%b pc=%h ins=%h", nm, act[129], act[128:97],
               act[96], act[95:64], act[63:32]);
    end
  endtask

  task automatic drive(logic st, logic rv, logic [31:0] rpc, logic g, logic r, logic [31:0] rd);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = r; imem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: next fetch address, one optional outstanding request (possibly stale),
  // and the word currently offered to decode.
  logic [31:0] m_pc, m_req_pc, m_ipc, m_ins;
  logic        m_out, m_stale, m_valid;

  initial begin
    logic        st, rv, g, r, e_req, consumed, loaded;
    logic [31:0] rpc, rd;
    int          words;

    tbl[0]  = mk(0,0,0,1,0,0,            1,32'h000,0,32'h000,32'h0);
    tbl[1]  = mk(0,0,0,0,1,32'h11111111, 0,32'h004,0,32'h000,32'h0);
    tbl[2]  = mk(0,0,0,1,0,0,            1,32'h004,1,32'h000,32'h11111111);
    tbl[3]  = mk(0,0,0,0,1,32'h8C220004, 0,32'h008,0,32'h000,32'h11111111);
    for (int i = 4; i <= 8; i++)
      tbl[i] = mk(1,0,0,1,0,0,           0,32'h008,1,32'h004,32'h8C220004);
    tbl[9]  = mk(0,0,0,1,0,0,            1,32'h008,1,32'h004,32'h8C220004);
    tbl[10] = mk(0,0,0,0,1,32'h33333333, 0,32'h00C,0,32'h004,32'h8C220004);
    tbl[11] = mk(0,0,0,1,0,0,            1,32'h00C,1,32'h008,32'h33333333);
    tbl[12] = mk(0,0,0,0,1,32'h44444444, 0,32'h010,0,32'h008,32'h33333333);
    tbl[13] = mk(0,0,0,1,0,0,            1,32'h010,1,32'h00C,32'h44444444);
    tbl[14] = mk(0,1,32'h200,0,0,0,      0,32'h014,0,32'h00C,32'h44444444);
    tbl[15] = mk(0,0,0,1,1,32'hDEADBEEF, 0,32'h200,0,32'h00C,32'h44444444);
    tbl[16] = mk(0,0,0,1,0,0,            1,32'h200,0,32'h00C,32'h44444444);
    tbl[17] = mk(0,0,0,0,1,32'h55555555, 0,32'h204,0,32'h00C,32'h44444444);
    tbl[18] = mk(1,1,32'h403,0,1,32'hBAD0BAD0, 0,32'h204,1,32'h200,32'h55555555);
    tbl[19] = mk(0,0,0,1,0,0,            1,32'h400,0,32'h200,32'h55555555);
    tbl[20] = mk(1,1,32'h303,0,1,32'hBADBAD00, 0,32'h404,0,32'h200,32'h55555555);
    tbl[21] = mk(1,0,0,0,0,0,            1,32'h300,0,32'h200,32'h55555555);
    tbl[22] = mk(1,0,0,0,0,0,            1,32'h300,0,32'h200,32'h55555555);
    tbl[23] = mk(1,0,0,1,0,0,            1,32'h300,0,32'h200,32'h55555555);
    tbl[24] = mk(0,0,0,0,0,0,            0,32'h304,0,32'h200,32'h55555555);
    tbl[25] = mk(0,0,0,0,1,32'h66666666, 0,32'h304,0,32'h200,32'h55555555);
    tbl[26] = mk(0,0,0,0,0,0,            1,32'h304,1,32'h300,32'h66666666);
    tbl[27] = mk(0,0,0,0,0,0,            1,32'h304,0,32'h300,32'h66666666);

    #3;
    chk("reset_state", ev(0, RESET_PC, 0, 32'h0, 32'h0), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].g, tbl[i].r, tbl[i].rd);
      chk($sformatf("row%0d", i), ev(tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc, tbl[i].e_ins), 1);
      tick();
    end

    // Address wrap at the top of memory, then asynchronous reset in the middle of WAIT.
    drive(0,1,32'hFFFFFFFF,0,0,0);
    chk("wrap_redirect", ev(0,32'h304,0,32'h300,32'h66666666), 1); tick();
    drive(0,0,0,1,0,0);
    chk("wrap_req", ev(1,32'hFFFFFFFC,0,32'h300,32'h66666666), 1); tick();
    drive(0,0,0,0,1,32'h77777777);
    chk("wrap_next_addr", ev(0,32'h0,0,32'h300,32'h66666666), 1); tick();
    drive(0,0,0,1,0,0);
    chk("wrap_word", ev(1,32'h0,1,32'hFFFFFFFC,32'h77777777), 1); tick();
    drive(0,0,0,0,0,0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", ev(0,RESET_PC,0,32'h0,32'h0), 1);
    tick();
    rst_n = 1'b1;
    drive(0,0,0,0,1,32'hBADBAD11);
    chk("late_rvalid", ev(1,RESET_PC,0,32'h0,32'h0), 1); tick();
    drive(0,0,0,1,0,0);
    chk("late_rvalid_ignored", ev(1,RESET_PC,0,32'h0,32'h0), 1); tick();
    drive(0,0,0,0,1,32'h12345678);
    chk("post_reset_wait", ev(0,RESET_PC+32'd4,0,32'h0,32'h0), 1); tick();
    drive(0,0,0,0,0,0);
    chk("post_reset_word", ev(1,RESET_PC+32'd4,1,RESET_PC,32'h12345678), 1); tick();

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_pc = RESET_PC; m_req_pc = 32'h0; m_ipc = 32'h0; m_ins = 32'h0;
    m_out = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
    words = 0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      g   = ($urandom_range(0, 9) < 7);
      r   = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rd  = $urandom;
      drive(st, rv, rpc, g, r, rd);
      e_req = !m_out && !rv && (!m_valid || !st);
      chk($sformatf("rand%0d", c), ev(e_req, m_pc, m_valid, m_ipc, m_ins), 0);

      consumed = m_valid && !st;
      loaded   = 1'b0;
      if (rv) begin
        m_pc    = rpc & ~32'h3;
        m_valid = 1'b0;
        if (m_out && r) begin
          m_out = 1'b0; m_stale = 1'b0;
        end else if (m_out) begin
          m_stale = 1'b1;
        end
      end else begin
        if (m_out && r) begin
          if (!m_stale) begin
            m_valid = 1'b1; m_ipc = m_req_pc; m_ins = rd; loaded = 1'b1;
            words++;
            $display("word %0d: pc=%h ins=%h", words, m_ipc, m_ins);
          end
          m_out = 1'b0; m_stale = 1'b0;
        end
        if (consumed && !loaded) m_valid = 1'b0;
        if (e_req && g) begin
          m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_out = 1'b1;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
